grid_pixel_pipe: RTL

- Parametrised, pipelined playfield colour mapper for the VGA path.
- Maps the current pixel (DrawX, DrawY) to 12-bit RGB from a multi-bit-per-cell playfield grid, using an 8-entry colour palette.
- Adds two sequential features: a frame-synchronous shadow copy of the grid (no mid-frame tearing) and a timed row-clear flash animation.
- Sits between the game logic (grid, clear mask) and the VGA output registers.

---
 rtl/grid_pixel_pipe.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/grid_pixel_pipe.sv
// grid_pixel_pipe: 3-stage playfield colour mapper with a frame-synchronous shadow grid.
// Define GRID_PIPE_FLASH_EN to build the timed row-clear flash animation.
`timescale 1ns/1ps
module grid_pixel_pipe #(
    parameter int COLS         = 10,
    parameter int ROWS         = 20,
    parameter int CELL_PX      = 24,
    parameter int ORIGIN_X     = 192,
    parameter int ORIGIN_Y     = 0,
    parameter int CELL_BITS    = 3,
    parameter int BORDER_PX    = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic                           pixel_valid,
    input  logic                           frame_start,
    input  logic [COLS*ROWS*CELL_BITS-1:0] grid,
    input  logic [ROWS-1:0]                clear_rows,
    output logic [3:0]                     Red,
    output logic [3:0]                     Green,
    output logic [3:0]                     Blue,
    output logic                           rgb_valid,
    output logic                           flash_done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int GW = COLS * ROWS * CELL_BITS;
    localparam int IW = (GW > 1) ? $clog2(GW) : 1;

    // Stage 1: range check, cell index and intra-cell offset
    logic          in_grid1_d, in_grid1_q;
    logic [CW-1:0] col1_d, col1_q;
    logic [RW-1:0] row1_d, row1_q;
    logic [OW-1:0] offx1_d, offx1_q;
    logic [OW-1:0] offy1_d, offy1_q;
    logic          valid1_q;
    logic [9:0]    dx, dy;

    // Stage 2: cell code, border and flash decisions
    logic                 in_grid2_q;
    logic [CELL_BITS-1:0] code2_d, code2_q;
    logic                 border2_d, border2_q;
    logic                 flash_hit_d, flash2_q;
    logic                 valid2_q;
    logic [IW-1:0]        cell_base;

    // Stage 3: registered colour
    logic [11:0] rgb3_d, rgb3_q;
    logic        valid3_q;

    logic [GW-1:0] shadow_q;

    function automatic logic [11:0] palette(input logic [CELL_BITS-1:0] code);
        logic [11:0] rgb;
        if (32'(code) >= 32'd8) begin
            rgb = 12'h888;
        end else begin
            case (code[2:0])
                3'd0:    rgb = 12'h135;
                3'd1:    rgb = 12'hF70;
                3'd2:    rgb = 12'h0FF;
                3'd3:    rgb = 12'hFF0;
                3'd4:    rgb = 12'hA0F;
                3'd5:    rgb = 12'h0F0;
                3'd6:    rgb = 12'hF00;
                default: rgb = 12'h00F;
            endcase
        end
        return rgb;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        in_grid1_d = 1'b0;
        dx         = DrawX - 10'(ORIGIN_X);
        dy         = DrawY - 10'(ORIGIN_Y);
        col1_d     = CW'(dx / 10'(CELL_PX));
        row1_d     = RW'(dy / 10'(CELL_PX));
        offx1_d    = OW'(dx % 10'(CELL_PX));
        offy1_d    = OW'(dy % 10'(CELL_PX));
        // Indices are only trusted when in_grid is set, so underflowed subtractions are harmless.
        if (int'(DrawX) >= ORIGIN_X && int'(DrawX) < ORIGIN_X + COLS * CELL_PX &&
            int'(DrawY) >= ORIGIN_Y && int'(DrawY) < ORIGIN_Y + ROWS * CELL_PX) begin
            in_grid1_d = 1'b1;
        end
    end

    always_comb begin
        code2_d   = '0;
        cell_base = IW'((int'(row1_q) * COLS + int'(col1_q)) * CELL_BITS);
        if (in_grid1_q) begin
            code2_d = shadow_q[cell_base +: CELL_BITS];
        end
        border2_d = (int'(offx1_q) < BORDER_PX) || (int'(offx1_q) >= CELL_PX - BORDER_PX) ||
                    (int'(offy1_q) < BORDER_PX) || (int'(offy1_q) >= CELL_PX - BORDER_PX);
    end

    always_comb begin
        rgb3_d = 12'h000;
        if (valid2_q && in_grid2_q) begin
            if (border2_q || flash2_q) begin
                rgb3_d = 12'hFFF;
            end else begin
                rgb3_d = palette(code2_q);
            end
        end
    end

    // NOTE: the shadow grid is built from flops, not RAM, so it is cleared by reset like any other state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_q <= '0;
        end else if (frame_start) begin
            shadow_q <= grid;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_grid1_q <= 1'b0;
            col1_q     <= '0;
            row1_q     <= '0;
            offx1_q    <= '0;
            offy1_q    <= '0;
            valid1_q   <= 1'b0;
            in_grid2_q <= 1'b0;
            code2_q    <= '0;
            border2_q  <= 1'b0;
            flash2_q   <= 1'b0;
            valid2_q   <= 1'b0;
            rgb3_q     <= 12'h000;
            valid3_q   <= 1'b0;
        end else begin
            in_grid1_q <= in_grid1_d;
            col1_q     <= col1_d;
            row1_q     <= row1_d;
            offx1_q    <= offx1_d;
            offy1_q    <= offy1_d;
            valid1_q   <= pixel_valid;
            in_grid2_q <= in_grid1_q;
            code2_q    <= code2_d;
            border2_q  <= border2_d;
            flash2_q   <= flash_hit_d;
            valid2_q   <= valid1_q;
            rgb3_q     <= rgb3_d;
            valid3_q   <= valid2_q;
        end
    end

`ifdef GRID_PIPE_FLASH_EN
    localparam int CNT_W = ($clog2(FLASH_FRAMES) < 2) ? 2 : $clog2(FLASH_FRAMES);

    typedef enum logic {IDLE, FLASH} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ROWS-1:0]  mask_q;
    logic             flash_done_q;

    // Counts frames since the request; the exit frame_start never re-arms in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            flash_done_q <= 1'b0;
        end else begin
            flash_done_q <= 1'b0;
            if (frame_start) begin
                case (state_q)
                    IDLE: begin
                        if (clear_rows != '0) begin
                            mask_q  <= clear_rows;
                            cnt_q   <= '0;
                            state_q <= FLASH;
                        end
                    end
                    FLASH: begin
                        if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                            flash_done_q <= 1'b1;
                            mask_q       <= '0;
                            cnt_q        <= '0;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign flash_hit_d = in_grid1_q && (state_q == FLASH) && cnt_q[1] && mask_q[row1_q];
    assign flash_done  = flash_done_q;
`else
    localparam int UNUSED_FLASH_FRAMES = FLASH_FRAMES;
    logic unused_clear_rows;

    assign unused_clear_rows = ^clear_rows;
    assign flash_hit_d       = 1'b0;
    assign flash_done        = 1'b0;
`endif

    assign Red       = rgb3_q[11:8];
    assign Green     = rgb3_q[7:4];
    assign Blue      = rgb3_q[3:0];
    assign rgb_valid = valid3_q;

endmodule
